mod_counter_ud: RTL and testbench

Parametrised, runtime-programmable modulo-N up/down counter. It is the general-purpose counting primitive for timebase, divider and time-of-day chains (seconds/minutes/hours). It adds enable, direction, synchronous clear and load, and a terminal-count output for cascading. The modulus is reprogrammable at run time with range checking.

---
 rtl/mod_counter_ud.sv | 136 +++++++++++++
 tb/tb_mod_counter_ud.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter_ud.sv
// ---------------------------------------------------------------------------
// mod_counter_ud
//   Runtime-programmable modulo-N up/down counter. It is intended for timebase,
//   divider and time-of-day chains. Count actions take effect in priority
//   order: clr, then load, then en. The modulus can be rewritten at run time
//   through mod_wr, and values outside the legal range are rejected.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clr       in   synchronous clear (cnt -> 0)
//   en        in   count enable
//   up_dn     in   direction, 1 = up, 0 = down
//   load      in   synchronous load of load_val (clamped to mod_cur-1)
//   load_val  in   [WIDTH-1:0] value for load
//   mod_wr    in   single-cycle strobe, write mod_val into mod_cur
//   mod_val   in   [WIDTH:0] new modulus, legal 2..2^WIDTH
//   cnt       out  [WIDTH-1:0] current count (registered)
//   mod_cur   out  [WIDTH:0] active modulus (registered)
//   tc        out  terminal count (combinational), used as next stage's en
//   wrap      out  one-cycle pulse after an edge on which cnt wrapped
//   err       out  one-cycle pulse after a clamped load or rejected mod_wr
//
// Interface timing: there is no handshake. Each strobe (clr, load, en,
// mod_wr) is sampled on every rising edge on which it is high. The block
// cannot stall, so it has no ready signal.
// ---------------------------------------------------------------------------
module mod_counter_ud #(
  parameter int WIDTH       = 6,
  parameter int MOD_DEFAULT = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mod_wr,
  input  logic [WIDTH:0]   mod_val,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH:0]   mod_cur,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  // Reject illegal parameterisations at elaboration time.
  if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
    $error("mod_counter_ud: WIDTH must be 1..16");
  end
  if (MOD_DEFAULT < 2 || MOD_DEFAULT > (1 << WIDTH)) begin : g_bad_mod
    $error("mod_counter_ud: MOD_DEFAULT must be 2..2^WIDTH");
  end

  localparam logic [WIDTH:0]   ONE_X   = (WIDTH+1)'(1);
  localparam logic [WIDTH:0]   TWO_X   = (WIDTH+1)'(2);
  localparam logic [WIDTH:0]   MOD_MAX = ONE_X << WIDTH;
  localparam logic [WIDTH:0]   MOD_RST = (WIDTH+1)'(MOD_DEFAULT);
  localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);

  // Compare in WIDTH+1 bits. With mod_cur = 2^WIDTH, last is all-ones and
  // does not truncate.
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   last;
  logic [WIDTH-1:0] cnt_nxt;
  logic             wrap_nxt;
  logic             load_err;
  logic             mod_ok;
  logic             mod_err;

  assign cnt_x = {1'b0, cnt};
  assign last  = mod_cur - ONE_X;

  assign tc = en & (up_dn ? (cnt_x == last) : (cnt == '0));

  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    load_err = 1'b0;
    mod_ok   = 1'b0;
    mod_err  = 1'b0;

    if (clr) begin
      cnt_nxt = '0;
    end else if (load) begin
      if ({1'b0, load_val} < mod_cur) begin
        cnt_nxt = load_val;
      end else begin
        cnt_nxt  = last[WIDTH-1:0];
        load_err = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (cnt_x == last) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + ONE_W;
        end
      end else begin
        if (cnt == '0) begin
          cnt_nxt  = last[WIDTH-1:0];
          wrap_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - ONE_W;
        end
      end
    end

    // Modulus write runs alongside the count chain. If the count that this
    // edge produces would fall outside the new range, force it to 0.
    mod_ok  = mod_wr && (mod_val >= TWO_X) && (mod_val <= MOD_MAX);
    mod_err = mod_wr && !mod_ok;
    if (mod_ok && ({1'b0, cnt_nxt} >= mod_val)) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mod_cur <= MOD_RST;
      wrap    <= 1'b0;
      err     <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
      err  <= load_err | mod_err;
      if (mod_ok) begin
        mod_cur <= mod_val;
      end
    end
  end

endmodule

// File: tb/tb_mod_counter_ud.sv
// ---------------------------------------------------------------------------
// tb_mod_counter_ud
//   Testbench for mod_counter_ud. It runs directed scenarios followed by
//   randomized stimulus. Results are compared against a reference model
//   that uses modular arithmetic. A two-stage cascade (mod 60 into mod 24)
//   is also exercised.
// ---------------------------------------------------------------------------
module tb_mod_counter_ud;

  localparam int W = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         clr, en, up_dn, load, mod_wr;
  logic [W-1:0] load_val;
  logic [W:0]   mod_val;
  logic [W-1:0] cnt;
  logic [W:0]   mod_cur;
  logic         tc, wrap, err;

  mod_counter_ud #(.WIDTH(W), .MOD_DEFAULT(60)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val), .mod_wr(mod_wr), .mod_val(mod_val),
    .cnt(cnt), .mod_cur(mod_cur), .tc(tc), .wrap(wrap), .err(err)
  );

  // ---------------- cascade: seconds (mod 60) -> stage 1 (mod 24) ----------
  logic         c_en, c_up, c_zero;
  logic [W-1:0] c_lv;
  logic [W:0]   c_mv;
  logic [W-1:0] c0_cnt, c1_cnt;
  logic [W:0]   c0_mod, c1_mod;
  logic         c0_tc, c1_tc, c0_wrap, c1_wrap, c0_err, c1_err;

  mod_counter_ud #(.WIDTH(W), .MOD_DEFAULT(60)) u_s0 (
    .clk(clk), .rst_n(rst_n), .clr(c_zero), .en(c_en), .up_dn(c_up),
    .load(c_zero), .load_val(c_lv), .mod_wr(c_zero), .mod_val(c_mv),
    .cnt(c0_cnt), .mod_cur(c0_mod), .tc(c0_tc), .wrap(c0_wrap), .err(c0_err)
  );

  mod_counter_ud #(.WIDTH(W), .MOD_DEFAULT(24)) u_s1 (
    .clk(clk), .rst_n(rst_n), .clr(c_zero), .en(c0_tc), .up_dn(c_up),
    .load(c_zero), .load_val(c_lv), .mod_wr(c_zero), .mod_val(c_mv),
    .cnt(c1_cnt), .mod_cur(c1_mod), .tc(c1_tc), .wrap(c1_wrap), .err(c1_err)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int wrap_seen;
  int m_cnt, m_mod;
  bit m_wrap, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model. It applies one clock edge of counter rules using
  // modular arithmetic on plain integers.
  function automatic void ref_step(inout int c, inout int m, output bit w, output bit e,
                                   input bit i_clr, input bit i_load, input int i_lv,
                                   input bit i_en, input bit i_up,
                                   input bit i_mw, input int i_mv);
    int nc;
    nc = c;
    w  = 0;
    e  = 0;
    if (i_clr) nc = 0;
    else if (i_load) begin
      if (i_lv < m) nc = i_lv;
      else begin nc = m - 1; e = 1; end
    end else if (i_en) begin
      if (i_up) begin nc = (c + 1) % m; w = (c == m - 1); end
      else      begin nc = (c + m - 1) % m; w = (c == 0); end
    end
    if (i_mw) begin
      if (i_mv >= 2 && i_mv <= (1 << W)) begin
        if (nc >= i_mv) nc = 0;
        m = i_mv;
      end else e = 1;
    end
    c = nc;
  endfunction

  function automatic bit ref_tc(input int c, input int m, input bit e, input bit u);
    return e && (u ? (c == m - 1) : (c == 0));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    clr = 0; en = 0; up_dn = 1; load = 0; load_val = '0; mod_wr = 0; mod_val = '0;
  endtask

  // One clock: check tc before the edge, advance the model, then check the
  // registered outputs just after the edge.
  task automatic step(input string tag);
    bit w, e;
    #1;
    check({tag, ".tc"}, 32'(tc), 32'(ref_tc(m_cnt, m_mod, en, up_dn)));
    @(posedge clk);
    ref_step(m_cnt, m_mod, w, e, clr, load, int'(load_val), en, up_dn, mod_wr, int'(mod_val));
    m_wrap = w;
    m_err  = e;
    #1;
    check({tag, ".cnt"},  32'(cnt),     32'(m_cnt));
    check({tag, ".mod"},  32'(mod_cur), 32'(m_mod));
    check({tag, ".wrap"}, 32'(wrap),    32'(m_wrap));
    check({tag, ".err"},  32'(err),     32'(m_err));
    if (wrap === 1'b1) wrap_seen++;
  endtask

  // Asynchronous reset. The outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rst_n = 0;
    #2;
    m_cnt = 0; m_mod = 60; m_wrap = 0; m_err = 0;
    check({tag, ".cnt"},  32'(cnt),     32'd0);
    check({tag, ".mod"},  32'(mod_cur), 32'd60);
    check({tag, ".wrap"}, 32'(wrap),    32'd0);
    check({tag, ".err"},  32'(err),     32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c0, c1, m0, m1, c1_wraps;
    bit w, e, t0;

    idle_inputs();
    c_en = 0; c_up = 1; c_zero = 0; c_lv = '0; c_mv = '0;
    rst_n = 1;
    #3;
    do_reset("reset");

    // Up count at the default modulus, 130 edges.
    en = 1; up_dn = 1; wrap_seen = 0;
    repeat (130) step("up60");
    check("up60.final_cnt", 32'(cnt), 32'd10);
    check("up60.wrap_count", 32'(wrap_seen), 32'd2);

    // Down count from reset. The first edge wraps 0 -> 59.
    do_reset("reset2");
    en = 1; up_dn = 0;
    step("down");
    check("down.first_cnt", 32'(cnt), 32'd59);
    check("down.first_wrap", 32'(wrap), 32'd1);
    repeat (5) step("down");
    up_dn = 1;                               // direction change, no dead cycle
    repeat (3) step("dirchg");

    // Clamped load, then clr wins over load.
    en = 0; load = 1; load_val = 6'd63;
    step("load_clamp");
    check("load_clamp.cnt", 32'(cnt), 32'd59);
    check("load_clamp.err", 32'(err), 32'd1);
    load_val = 6'd20; clr = 1;
    step("clr_over_load");
    check("clr_over_load.cnt", 32'(cnt), 32'd0);
    check("clr_over_load.err", 32'(err), 32'd0);
    clr = 0;

    // Out-of-range fix-up when the modulus shrinks below the count.
    load_val = 6'd45;
    step("load45");
    load = 0; en = 1; up_dn = 1; mod_wr = 1; mod_val = 7'd24;
    step("fixup");
    check("fixup.cnt", 32'(cnt), 32'd0);
    check("fixup.mod", 32'(mod_cur), 32'd24);
    mod_wr = 0;
    repeat (30) step("up24");

    // Rejected moduli, then 2^W accepted and wrapping at 63 -> 0.
    en = 0; mod_wr = 1; mod_val = 7'd1;
    step("mod_lo");
    check("mod_lo.err", 32'(err), 32'd1);
    mod_val = 7'd65;
    step("mod_hi");
    check("mod_hi.err", 32'(err), 32'd1);
    check("mod_hi.mod", 32'(mod_cur), 32'd24);
    mod_val = 7'd64;
    step("mod64");
    check("mod64.mod", 32'(mod_cur), 32'd64);
    mod_wr = 0; load = 1; load_val = 6'd62;
    step("load62");
    load = 0; en = 1;
    repeat (4) step("up64");
    check("up64.cnt", 32'(cnt), 32'd2);

    // Modulus 2 with en held high gives a wrap every other cycle.
    en = 0; mod_wr = 1; mod_val = 7'd2;
    step("mod2");
    mod_wr = 0; en = 1;
    repeat (8) step("up2");

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    #3;
    do_reset("midreset");
    m_cnt = 0;
    en = 1; up_dn = 1;
    step("after_reset");
    check("after_reset.cnt", 32'(cnt), 32'd1);

    // Randomized stimulus.
    for (int i = 0; i < 600; i++) begin
      clr      = ($urandom_range(0, 19) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom_range(0, (1 << W) - 1));
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = ($urandom_range(0, 1) == 1);
      mod_wr   = ($urandom_range(0, 14) == 0);
      mod_val  = (W+1)'($urandom_range(0, (1 << W) + 6));
      step("rand");
    end
    idle_inputs();

    // Cascade: 1440 edges is one full 60 x 24 cycle.
    c0 = 0; c1 = 0; m0 = 60; m1 = 24; c1_wraps = 0;
    c_en = 1; c_up = 1;
    for (int i = 0; i < 1440; i++) begin
      #1;
      t0 = ref_tc(c0, m0, c_en, c_up);
      check("casc.tc0", 32'(c0_tc), 32'(t0));
      @(posedge clk);
      ref_step(c0, m0, w, e, 0, 0, 0, c_en, c_up, 0, 0);
      ref_step(c1, m1, w, e, 0, 0, 0, t0, c_up, 0, 0);
      #1;
      check("casc.cnt0", 32'(c0_cnt), 32'(c0));
      check("casc.cnt1", 32'(c1_cnt), 32'(c1));
      check("casc.wrap1", 32'(c1_wrap), 32'(w));
      if (c1_wrap === 1'b1) c1_wraps++;
    end
    c_en = 0;
    check("casc.end_cnt0", 32'(c0_cnt), 32'd0);
    check("casc.end_cnt1", 32'(c1_cnt), 32'd0);
    check("casc.wrap1_count", 32'(c1_wraps), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
